// File: rtl/relu_array_scheduler.sv
// Streams feature chunks from the feature buffer through an external reluArray
// and writes the activated chunks back, with credit-managed output buffering.
module relu_array_scheduler #(
    parameter int dataWidth   = 32,
    parameter int pactivation = 128,
    parameter int addrWidth   = 10,
    parameter int reluLatency = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [addrWidth-1:0]             numChunks,
    input  logic [addrWidth-1:0]             baseRdAddr,
    input  logic [addrWidth-1:0]             baseWrAddr,
    output logic                             busy,
    output logic                             done,
    output logic                             rdEn,
    output logic [addrWidth-1:0]             rdAddr,
    input  logic [dataWidth*pactivation-1:0] rdData,
    output logic [dataWidth*pactivation-1:0] reluIn,
    input  logic [dataWidth*pactivation-1:0] reluOut,
    output logic                             wrEn,
    output logic [addrWidth-1:0]             wrAddr,
    output logic [dataWidth*pactivation-1:0] wrData,
    input  logic                             wrReady
);

    localparam int W     = dataWidth * pactivation;
    localparam int DEPTH = reluLatency + 3;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [addrWidth-1:0] r_num;
    logic [addrWidth-1:0] r_rd_base;
    logic [addrWidth-1:0] r_wr_base;
    logic [addrWidth-1:0] r_issued;
    logic [addrWidth-1:0] r_written;
    logic [reluLatency:0] r_vld;
    logic [W-1:0]         r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_rd_en;
    logic                 w_wr_en;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_credit_ok;
    logic [CW-1:0]        w_inflight;
    logic [CW:0]          w_occupancy;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every chunk between read issue and FIFO exit holds one credit.
    always_comb begin
        // NOTE: combinational accumulation uses blocking '=' with a default first, so no latch is inferred.
        w_inflight = '0;
        for (int i = 0; i <= reluLatency; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
        w_occupancy = {1'b0, r_count} + {1'b0, w_inflight};
    end

    assign w_credit_ok = w_occupancy < (CW + 1)'(DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = r_vld[reluLatency];
    assign w_rd_en     = (r_state == S_RUN) && (r_issued < r_num) && w_credit_ok;
    assign w_wr_en     = (r_state != S_IDLE) && !w_empty && wrReady;

    assign busy   = r_busy;
    assign done   = r_done;
    assign rdEn   = w_rd_en;
    assign rdAddr = r_rd_base + r_issued;
    assign reluIn = rdData;
    assign wrEn   = w_wr_en;
    assign wrAddr = r_wr_base + r_written;
    assign wrData = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_num     <= '0;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_issued  <= '0;
            r_written <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_rd_en) r_issued <= r_issued + 1'b1;
            if (w_wr_en) r_written <= r_written + 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num     <= numChunks;
                        r_rd_base <= baseRdAddr;
                        r_wr_base <= baseWrAddr;
                        r_issued  <= '0;
                        r_written <= '0;
                        r_busy    <= 1'b1;
                        if (numChunks == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en && (r_issued == r_num - 1'b1)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_wr_en && (r_written == r_num - 1'b1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The valid shift register mirrors the reluArray pipeline; its tail pushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_vld <= {r_vld[reluLatency-1:0], w_rd_en};
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_wr_en) r_rd_ptr <= f_next(r_rd_ptr);
            unique case ({w_push, w_wr_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to zero while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= reluOut;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_relu_array_scheduler.sv
// Directed bench: two scheduler instances (reluLatency 1 and 2) driven in parallel
// against a feature-buffer model and a behavioural reluArray pipeline.
module tb_relu_array_scheduler;

    localparam int DW = 32;
    localparam int PA = 2;
    localparam int AW = 10;
    localparam int W  = DW * PA;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic [AW-1:0] numChunks  = '0;
    logic [AW-1:0] baseRdAddr = '0;
    logic [AW-1:0] baseWrAddr = '0;
    logic          wrReady    = 1'b1;

    logic          busy1, done1, rdEn1, wrEn1;
    logic [AW-1:0] rdAddr1, wrAddr1;
    logic [W-1:0]  rdData1 = '0;
    logic [W-1:0]  reluIn1, reluOut1, wrData1;
    logic          busy2, done2, rdEn2, wrEn2;
    logic [AW-1:0] rdAddr2, wrAddr2;
    logic [W-1:0]  rdData2 = '0;
    logic [W-1:0]  reluIn2, reluOut2, wrData2;
    logic [W-1:0]  relu1_q = '0, relu2_a = '0, relu2_b = '0;

    logic [W-1:0]  feat [1024];
    int            cyc = 0;
    int            t0  = 0;
    int            n_tests = 0;
    int            n_fail  = 0;

    int           rd_cnt1 = 0, wr_cnt1 = 0, done_cnt1 = 0, done_cyc1 = 0;
    int           rd_cnt2 = 0, wr_cnt2 = 0, done_cnt2 = 0, done_cyc2 = 0, max_out2 = 0;
    logic         done_busy1 = 1'b0;
    int           rd_addr1 [256];
    int           rd_cyc1  [256];
    int           wr_addr1 [256];
    int           wr_cyc1  [256];
    logic [W-1:0] wr_data1 [256];
    int           wr_addr2 [256];
    int           wr_cyc2  [256];
    logic [W-1:0] wr_data2 [256];

    relu_array_scheduler #(.dataWidth(DW), .pactivation(PA), .addrWidth(AW), .reluLatency(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .numChunks(numChunks),
        .baseRdAddr(baseRdAddr), .baseWrAddr(baseWrAddr),
        .busy(busy1), .done(done1), .rdEn(rdEn1), .rdAddr(rdAddr1), .rdData(rdData1),
        .reluIn(reluIn1), .reluOut(reluOut1), .wrEn(wrEn1), .wrAddr(wrAddr1),
        .wrData(wrData1), .wrReady(wrReady)
    );

    relu_array_scheduler #(.dataWidth(DW), .pactivation(PA), .addrWidth(AW), .reluLatency(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .numChunks(numChunks),
        .baseRdAddr(baseRdAddr), .baseWrAddr(baseWrAddr),
        .busy(busy2), .done(done2), .rdEn(rdEn2), .rdAddr(rdAddr2), .rdData(rdData2),
        .reluIn(reluIn2), .reluOut(reluOut2), .wrEn(wrEn2), .wrAddr(wrAddr2),
        .wrData(wrData2), .wrReady(wrReady)
    );

    assign reluOut1 = relu1_q;
    assign reluOut2 = relu2_b;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] relu_word(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x;
        for (int l = 0; l < PA; l++) begin
            if (x[l*DW+DW-1]) y[l*DW +: DW] = '0;
        end
        return y;
    endfunction

    // Lane 1 carries the address, lane 0 is negative for odd addresses.
    function automatic logic [W-1:0] feat_word(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {v, (a[0] ? -v : (v << 4))};
    endfunction

    function automatic logic [W-1:0] exp_word(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {v, (a[0] ? 32'd0 : (v << 4))};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdEn1) rdData1 <= feat[rdAddr1];
        if (rdEn2) rdData2 <= feat[rdAddr2];
        relu1_q <= relu_word(reluIn1);
        relu2_a <= relu_word(reluIn2);
        relu2_b <= relu2_a;
    end

    always @(negedge clk) begin
        if (rdEn1) begin
            rd_addr1[rd_cnt1] = int'(rdAddr1);
            rd_cyc1[rd_cnt1]  = cyc - t0;
            rd_cnt1++;
        end
        if (wrEn1) begin
            wr_addr1[wr_cnt1] = int'(wrAddr1);
            wr_data1[wr_cnt1] = wrData1;
            wr_cyc1[wr_cnt1]  = cyc - t0;
            wr_cnt1++;
        end
        if (done1) begin
            done_cnt1++;
            done_cyc1  = cyc - t0;
            done_busy1 = busy1;
        end
        if (rdEn2) rd_cnt2++;
        if (wrEn2) begin
            wr_addr2[wr_cnt2] = int'(wrAddr2);
            wr_data2[wr_cnt2] = wrData2;
            wr_cyc2[wr_cnt2]  = cyc - t0;
            wr_cnt2++;
        end
        if (rd_cnt2 - wr_cnt2 > max_out2) max_out2 = rd_cnt2 - wr_cnt2;
        if (done2) begin
            done_cnt2++;
            done_cyc2 = cyc - t0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one job (both instances) and wait, bounded, until both report done.
    task automatic run(input int n, input int rd_base, input int wr_base,
                       input int lo, input int hi, input int restart);
        int d1, d2;
        bit ok;
        d1 = done_cnt1;
        d2 = done_cnt2;
        ok = 1'b0;
        numChunks  = AW'(n);
        baseRdAddr = AW'(rd_base);
        baseWrAddr = AW'(wr_base);
        wrReady    = 1'b1;
        start      = 1'b1;
        t0         = cyc;
        for (int c = 1; c <= 300; c++) begin
            step();
            start = (c == restart);
            if (c == restart) begin
                numChunks  = 10'd3;
                baseRdAddr = 10'h300;
                baseWrAddr = 10'h180;
            end
            wrReady = !(c >= lo && c <= hi);
            if (done_cnt1 != d1 && done_cnt2 != d2) begin
                ok = 1'b1;
                break;
            end
        end
        check("run completes", 64'(ok), 64'd1);
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r1, w1, dn1, r2, w2;
        int wrap_addr [4];
        logic [W-1:0] exp_t1 [4];
        exp_t1    = '{{32'd3, 32'd0}, {32'd0, 32'd7}, {32'h7FFF_FFFF, 32'd0}, {32'd100, 32'd0}};
        wrap_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        for (int a = 0; a < 1024; a++) feat[a] = feat_word(a);
        feat[16] = {32'd3,          32'hFFFF_FFFB};
        feat[17] = {32'hFFFF_FFFF,  32'd7};
        feat[18] = {32'h7FFF_FFFF,  32'd0};
        feat[19] = {32'd100,        32'h8000_0000};

        // Reset state
        step();
        check("rst busy",   64'(busy1),   64'd0);
        check("rst done",   64'(done1),   64'd0);
        check("rst rdEn",   64'(rdEn1),   64'd0);
        check("rst wrEn",   64'(wrEn1),   64'd0);
        check("rst rdAddr", 64'(rdAddr1), 64'd0);
        check("rst wrAddr", 64'(wrAddr1), 64'd0);
        check("rst wrData", 64'(wrData1), 64'd0);
        rst = 1'b0;
        repeat (2) step();

        // L=1, N=4 basic stream with signed lane values
        r1 = rd_cnt1; w1 = wr_cnt1; dn1 = done_cnt1;
        run(4, 'h10, 'h20, 1000, 0, -1);
        check("t1 write count", 64'(wr_cnt1 - w1), 64'd4);
        check("t1 done count", 64'(done_cnt1 - dn1), 64'd1);
        check("t1 done cycle", 64'(done_cyc1), 64'd8);
        check("t1 first rd cycle", 64'(rd_cyc1[r1]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1 rd addr %0d", k), 64'(rd_addr1[r1+k]), 64'(16 + k));
            check($sformatf("t1 wr addr %0d", k), 64'(wr_addr1[w1+k]), 64'(32 + k));
            check($sformatf("t1 wr data %0d", k), 64'(wr_data1[w1+k]), exp_t1[k]);
            check($sformatf("t1 wr cycle %0d", k), 64'(wr_cyc1[w1+k]), 64'(4 + k));
        end

        // N=0: immediate done, no traffic
        r1 = rd_cnt1; w1 = wr_cnt1; r2 = rd_cnt2; w2 = wr_cnt2;
        run(0, 5, 5, 1000, 0, -1);
        check("n0 done cycle", 64'(done_cyc1), 64'd1);
        check("n0 busy at done", 64'(done_busy1), 64'd1);
        check("n0 done cycle L2", 64'(done_cyc2), 64'd1);
        check("n0 no reads", 64'(rd_cnt1 - r1), 64'd0);
        check("n0 no writes", 64'(wr_cnt1 - w1), 64'd0);
        check("n0 no reads L2", 64'(rd_cnt2 - r2), 64'd0);
        check("n0 no writes L2", 64'(wr_cnt2 - w2), 64'd0);

        // L=2, N=16 with backpressure in cycles 6..15
        r2 = rd_cnt2; w2 = wr_cnt2;
        run(16, 'h40, 'h80, 6, 15, -1);
        check("bp write count", 64'(wr_cnt2 - w2), 64'd16);
        check("bp read count", 64'(rd_cnt2 - r2), 64'd16);
        check("bp max occupancy", 64'(max_out2), 64'd5);
        check("bp first wr cycle", 64'(wr_cyc2[w2]), 64'd5);
        check("bp second wr cycle", 64'(wr_cyc2[w2+1]), 64'd16);
        check("bp done after last", 64'(done_cyc2), 64'(wr_cyc2[w2+15] + 1));
        for (int k = 0; k < 16; k++) begin
            check($sformatf("bp wr addr %0d", k), 64'(wr_addr2[w2+k]), 64'('h80 + k));
            check($sformatf("bp wr data %0d", k), 64'(wr_data2[w2+k]), exp_word('h40 + k));
        end

        // Second start in cycle 3 is ignored
        r1 = rd_cnt1; w1 = wr_cnt1; dn1 = done_cnt1;
        run(8, 'h100, 'h200, 1000, 0, 3);
        check("rs write count", 64'(wr_cnt1 - w1), 64'd8);
        check("rs read count", 64'(rd_cnt1 - r1), 64'd8);
        check("rs done count", 64'(done_cnt1 - dn1), 64'd1);
        check("rs done cycle", 64'(done_cyc1), 64'd12);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rs rd addr %0d", k), 64'(rd_addr1[r1+k]), 64'('h100 + k));
            check($sformatf("rs wr addr %0d", k), 64'(wr_addr1[w1+k]), 64'('h200 + k));
            check($sformatf("rs wr data %0d", k), 64'(wr_data1[w1+k]), exp_word('h100 + k));
        end

        // Reset in cycle 5 of an N=8 run, then a fresh N=2 job
        dn1 = done_cnt1;
        numChunks  = 10'd8;
        baseRdAddr = 10'h50;
        baseWrAddr = 10'h60;
        start      = 1'b1;
        t0         = cyc;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("ar busy",   64'(busy1),   64'd0);
        check("ar done",   64'(done1),   64'd0);
        check("ar rdEn",   64'(rdEn1),   64'd0);
        check("ar wrEn",   64'(wrEn1),   64'd0);
        check("ar rdAddr", 64'(rdAddr1), 64'd0);
        check("ar wrAddr", 64'(wrAddr1), 64'd0);
        check("ar wrData", 64'(wrData1), 64'd0);
        check("ar wrEn L2", 64'(wrEn2),  64'd0);
        check("ar busy L2", 64'(busy2),  64'd0);
        step();
        rst = 1'b0;
        w1 = wr_cnt1;
        repeat (4) step();
        check("ar no stale writes", 64'(wr_cnt1 - w1), 64'd0);
        check("ar no done", 64'(done_cnt1 - dn1), 64'd0);
        run(2, 'h70, 'h90, 1000, 0, -1);
        check("ar write count", 64'(wr_cnt1 - w1), 64'd2);
        check("ar done count", 64'(done_cnt1 - dn1), 64'd1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ar wr addr %0d", k), 64'(wr_addr1[w1+k]), 64'('h90 + k));
            check($sformatf("ar wr data %0d", k), 64'(wr_data1[w1+k]), exp_word('h70 + k));
        end

        // Address wrap-around at 0x3FF
        r1 = rd_cnt1; w1 = wr_cnt1;
        run(4, 'h3FE, 'h3FE, 1000, 0, -1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap rd addr %0d", k), 64'(rd_addr1[r1+k]), 64'(wrap_addr[k]));
            check($sformatf("wrap wr addr %0d", k), 64'(wr_addr1[w1+k]), 64'(wrap_addr[k]));
            check($sformatf("wrap wr data %0d", k), 64'(wr_data1[w1+k]), exp_word(wrap_addr[k]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
